// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side FIFO consumer presenting popped words as a valid/ready stream
//
// Ports:
//   rclk_i       read-domain clock, rising edge
//   rrst_i       synchronous active-high reset
//   enable_i     permits popping the FIFO
//   rempty_i     FIFO empty flag
//   rdata_i      FIFO read data, valid whenever rempty_i=0
//   rinc_o       FIFO pop strobe (combinational)
//   m_data_o     stream data (head of skid buffer)
//   m_valid_o    stream valid
//   m_ready_i    stream ready from downstream
//   m_last_o     final word of a burst
//   words_out_o  count of completed stream transfers (wrapping)
//   busy_o       high whenever the FSM is not IDLE
module fifo_stream_reader #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             rclk_i,
    input  logic             rrst_i,
    input  logic             enable_i,
    input  logic             rempty_i,
    input  logic [DSIZE-1:0] rdata_i,
    output logic             rinc_o,
    output logic [DSIZE-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic [CNT_W-1:0] words_out_o,
    output logic             busy_o
);
    localparam int PW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic [DSIZE-1:0] head_data_q, head_data_d;
    logic             head_last_q, head_last_d;
    logic [DSIZE-1:0] skid_data_q, skid_data_d;
    logic             skid_last_q, skid_last_d;
    logic [PW-1:0]    push_idx_q, push_idx_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             push, pop, tag_last;

    // Gating on occupancy (not on m_ready) keeps the pop path free of any
    // combinational dependence on the downstream consumer.
    assign rinc_o      = enable_i & ~rempty_i & (occ_q < 2'd2) & ~rrst_i;
    assign push        = rinc_o;
    assign pop         = m_valid_o & m_ready_i;
    assign tag_last    = push_idx_q == LAST_IDX;
    assign m_valid_o   = occ_q != 2'd0;
    assign m_data_o    = head_data_q;
    assign m_last_o    = head_last_q;
    assign words_out_o = words_q;
    assign busy_o      = state_q != IDLE;

    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
        // Full buffer never pushes, so only the skid-to-head shift applies.
        // Otherwise a new word lands at head when the buffer is or becomes
        // empty of older words, else behind the head in the skid slot.
        if (occ_q == 2'd2) begin
            if (pop) begin
                head_data_d = skid_data_q;
                head_last_d = skid_last_q;
            end
        end else if (push) begin
            if (occ_q == 2'd0 || pop) begin
                head_data_d = rdata_i;
                head_last_d = tag_last;
            end else begin
                skid_data_d = rdata_i;
                skid_last_d = tag_last;
            end
        end
        push_idx_d = push ? (tag_last ? '0 : push_idx_q + 1'b1) : push_idx_q;
        words_d    = words_q + CNT_W'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable_i ? RUN : IDLE;
            RUN:     state_d = enable_i ? RUN : (occ_d != 2'd0 ? DRAIN : IDLE);
            DRAIN:   state_d = enable_i ? RUN : (occ_d == 2'd0 ? IDLE : DRAIN);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            push_idx_q  <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            push_idx_q  <= push_idx_d;
            words_q     <= words_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: queue-based reference model bench for fifo_stream_reader
module tb_fifo_stream_reader;
    localparam int DSIZE = 8;
    localparam int BL    = 4;
    localparam int CNT_W = 16;

    logic             rclk_i = 1'b0;
    logic             rrst_i, enable_i, rempty_i, m_ready_i;
    logic [DSIZE-1:0] rdata_i;
    logic             rinc_o, m_valid_o, m_last_o, busy_o;
    logic [DSIZE-1:0] m_data_o;
    logic [CNT_W-1:0] words_out_o;

    fifo_stream_reader #(.DSIZE(DSIZE), .BURST_LEN(BL), .CNT_W(CNT_W)) dut (
        .rclk_i(rclk_i), .rrst_i(rrst_i), .enable_i(enable_i), .rempty_i(rempty_i),
        .rdata_i(rdata_i), .rinc_o(rinc_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_last_o(m_last_o), .words_out_o(words_out_o), .busy_o(busy_o)
    );

    always #5 rclk_i = ~rclk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [DSIZE-1:0] src[$];
    logic [DSIZE:0]   mq[$];
    logic [DSIZE:0]   xlog[$];
    int               m_idx = 0;
    logic [CNT_W-1:0] m_words = '0;
    int               m_st = 0;

    logic rst_k = 1'b0, en_k = 1'b0;
    int   rdy_pct = 100;
    int   hole_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic hole, e_rinc, e_valid, xfer;
        int n;
        @(negedge rclk_i);
        cyc++;
        hole      = hole_mode == 1 ? cyc[0] : (hole_mode == 2 ? ($urandom_range(99) < 30) : 1'b0);
        rrst_i    = rst_k;
        enable_i  = en_k;
        m_ready_i = $urandom_range(99) < rdy_pct;
        rempty_i  = (src.size() == 0) || hole;
        rdata_i   = src.size() != 0 ? src[0] : DSIZE'($urandom);
        #1;
        e_rinc  = enable_i && !rempty_i && mq.size() < 2 && !rrst_i;
        e_valid = mq.size() != 0;
        chk("rinc", rinc_o, e_rinc);
        chk("m_valid", m_valid_o, e_valid);
        chk("words_out", words_out_o, m_words);
        chk("busy", busy_o, m_st != 0);
        if (e_valid) begin
            chk("m_data", m_data_o, mq[0][DSIZE-1:0]);
            chk("m_last", m_last_o, mq[0][DSIZE]);
        end
        xfer = e_valid && m_ready_i;
        @(posedge rclk_i);
        if (rrst_i) begin
            mq = {};
            m_idx = 0;
            m_words = '0;
            m_st = 0;
        end else begin
            if (xfer) begin
                xlog.push_back(mq.pop_front());
                m_words++;
            end
            if (e_rinc) begin
                mq.push_back({m_idx == BL - 1, src.pop_front()});
                m_idx = (m_idx + 1) % BL;
            end
            n = mq.size();
            if (m_st == 0) m_st = en_k ? 1 : 0;
            else if (en_k) m_st = 1;
            else m_st = n != 0 ? 2 : 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) src.push_back(DSIZE'(base + i));
    endtask

    task automatic chk_log(input string nm, input int base, input int n, input logic [31:0] lmask);
        chk({nm, "_count"}, xlog.size(), n);
        for (int i = 0; i < n && i < xlog.size(); i++) begin
            chk({nm, "_data"}, xlog[i][DSIZE-1:0], DSIZE'(base + i));
            chk({nm, "_last"}, xlog[i][DSIZE], lmask[i]);
        end
        xlog = {};
    endtask

    initial begin
        rrst_i = 1'b1; enable_i = 1'b0; rempty_i = 1'b1; m_ready_i = 1'b0; rdata_i = '0;
        repeat (3) @(posedge rclk_i);

        // Idle with empty FIFO
        en_k = 1'b1;
        run(5);
        #1;
        chk("t1_rinc", rinc_o, 0);
        chk("t1_valid", m_valid_o, 0);
        chk("t1_words", words_out_o, 0);
        chk("t1_busy", busy_o, 1);

        // Full-throughput streaming
        xlog = {};
        load(8'h10, 8);
        run(12);
        #1;
        chk("t2_words", words_out_o, 8);
        chk_log("t2", 8'h10, 8, 32'h88);

        // Backpressure
        load(8'h20, 6);
        rdy_pct = 0;
        run(4);
        #1;
        chk("t3_hold", m_data_o, 8'h20);
        chk("t3_rinc", rinc_o, 0);
        chk("t3_valid", m_valid_o, 1);
        rdy_pct = 100;
        run(10);
        chk_log("t3", 8'h20, 6, 32'h08);

        // Drain then resume with unbroken burst cadence
        load(8'h30, 8);
        rdy_pct = 0;
        run(3);
        en_k = 1'b0;
        rdy_pct = 100;
        run(3);
        #1;
        chk("t4_busy", busy_o, 0);
        chk("t4_rinc", rinc_o, 0);
        chk_log("t4a", 8'h30, 2, 32'h02);
        en_k = 1'b1;
        run(10);
        chk_log("t4b", 8'h32, 6, 32'h08);

        // Mid-stream reset
        load(8'h50, 6);
        rdy_pct = 0;
        run(3);
        rst_k = 1'b1;
        run(1);
        #1;
        chk("t6_valid", m_valid_o, 0);
        chk("t6_words", words_out_o, 0);
        rst_k = 1'b0;
        src = {};
        xlog = {};
        load(8'h40, 4);
        rdy_pct = 100;
        run(8);
        chk_log("t6", 8'h40, 4, 32'h08);

        // Sparse FIFO
        load(8'h60, 16);
        hole_mode = 1;
        run(40);
        chk_log("t5", 8'h60, 16, 32'h8888);

        // Randomized traffic
        hole_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 4) src.push_back(DSIZE'($urandom));
            if (i % 50 == 0) rdy_pct = $urandom_range(100);
            en_k  = ($urandom_range(7) != 0);
            rst_k = ($urandom_range(199) == 0);
            step();
        end
        xlog = {};

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
